// File: rtl/key_pkg.sv
// Shared types and defaults for the pushbutton debouncer.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ARM_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    ARM_RELEASE = 2'd3
  } key_state_t;

  localparam int unsigned DEFAULT_STABLE_CYCLES = 1_000_000;

endpackage

// File: rtl/key_debouncer_sync2.sv
// Two-flop synchronizer for slow asynchronous inputs (keys, switches).
// RESET_VAL selects the level both stages take during reset.
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/key_debouncer.sv
// Debouncer for one active-low key: level, press/release pulses, optional toggle.
// Define KEY_DEBOUNCER_TOGGLE_EN to build the toggle flop; otherwise toggle is tied 0.
module key_debouncer
  import key_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic CLK,
  input  logic reset,
  input  logic KEYb,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic toggle
);

  localparam int unsigned     CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic key_s;

  sync2 #(.RESET_VAL(1'b1)) u_sync_key (
    .clk (CLK),
    .rst (reset),
    .d   (KEYb),
    .q   (key_s)
  );

  key_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pressed_q, pressed_d;
  logic             press_pulse_q, press_pulse_d;
  logic             release_pulse_q, release_pulse_d;

  // The arming sample counts as 1, so a commit needs STABLE_CYCLES agreeing samples.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    pressed_d       = pressed_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!key_s) begin
          state_d = ARM_PRESS;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      ARM_PRESS: begin
        if (key_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = PRESSED;
          pressed_d     = 1'b1;
          press_pulse_d = 1'b1;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (key_s) begin
          state_d = ARM_RELEASE;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      ARM_RELEASE: begin
        if (!key_s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d         = IDLE;
          pressed_d       = 1'b0;
          release_pulse_d = 1'b1;
          cnt_d           = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;

`ifdef KEY_DEBOUNCER_TOGGLE_EN
  logic toggle_q, toggle_d;

  always_comb begin
    toggle_d = press_pulse_d ? ~toggle_q : toggle_q;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      toggle_q <= 1'b0;
    end else begin
      toggle_q <= toggle_d;
    end
  end

  assign toggle = toggle_q;
`else
  assign toggle = 1'b0;
`endif

endmodule

// File: tb/tb_key_debouncer.sv
// Directed self-checking bench for key_debouncer with STABLE_CYCLES=4.
module tb_key_debouncer;

  logic CLK = 1'b0;
  logic reset;
  logic KEYb;
  logic pressed;
  logic press_pulse;
  logic release_pulse;
  logic toggle;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;
  logic        exp_toggle = 1'b0;

`ifdef KEY_DEBOUNCER_TOGGLE_EN
  localparam bit TOG_EN = 1'b1;
`else
  localparam bit TOG_EN = 1'b0;
`endif

  key_debouncer #(.STABLE_CYCLES(4)) dut (
    .CLK           (CLK),
    .reset         (reset),
    .KEYb          (KEYb),
    .pressed       (pressed),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .toggle        (toggle)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    reset = 1'b1;
    KEYb  = 1'b1;
    #2;
    obs = {pressed, press_pulse, release_pulse, toggle};
    vectors++;
    if (obs !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_async: outputs=%b expected=0000", obs);
    end
    tick();
    tick();
    @(negedge CLK);
    reset = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      obs = {pressed, press_pulse, release_pulse, toggle};
      vectors++;
      if (obs !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_idle edge %0d: outputs=%b expected=0000", i, obs);
      end
    end
  endtask

  // KEYb must already be low ahead of the first edge of this window.
  task automatic press_window(input string name);
    logic [3:0] obs, exp;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 6 && TOG_EN) exp_toggle = ~exp_toggle;
      exp = {(i >= 6), (i == 6), 1'b0, exp_toggle};
      obs = {pressed, press_pulse, release_pulse, toggle};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL %s edge %0d: {pressed,press_p,release_p,toggle}=%b expected=%b",
                 name, i, obs, exp);
      end
    end
  endtask

  task automatic test_clean_press();
    KEYb = 1'b0;
    press_window("clean_press");
  endtask

  task automatic test_release(input string name);
    logic [3:0] obs, exp;
    KEYb = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      exp = {(i < 6), 1'b0, (i == 6), exp_toggle};
      obs = {pressed, press_pulse, release_pulse, toggle};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL %s edge %0d: {pressed,press_p,release_p,toggle}=%b expected=%b",
                 name, i, obs, exp);
      end
    end
    for (int i = 0; i < 3; i++) tick();
  endtask

  // Low for edges 1-3, high at 4, low from 5: the window restarts at edge 5.
  task automatic test_bounce();
    logic [3:0] obs, exp;
    for (int i = 1; i <= 11; i++) begin
      KEYb = (i == 4) ? 1'b1 : 1'b0;
      tick();
      if (i == 10 && TOG_EN) exp_toggle = ~exp_toggle;
      exp = {(i >= 10), (i == 10), 1'b0, exp_toggle};
      obs = {pressed, press_pulse, release_pulse, toggle};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL bounce edge %0d: {pressed,press_p,release_p,toggle}=%b expected=%b",
                 i, obs, exp);
      end
    end
  endtask

  task automatic test_short_glitch();
    logic [3:0] obs;
    for (int i = 1; i <= 10; i++) begin
      KEYb = (i <= 3) ? 1'b0 : 1'b1;
      tick();
      obs = {pressed, press_pulse, release_pulse, toggle};
      vectors++;
      if (obs !== {3'b000, exp_toggle}) begin
        miscompares++;
        $display("FAIL short_glitch edge %0d: outputs=%b expected=%b",
                 i, obs, {3'b000, exp_toggle});
      end
    end
  endtask

  task automatic test_reset_mid_arm();
    logic [3:0] obs;
    KEYb = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    #1;
    exp_toggle = 1'b0;
    obs = {pressed, press_pulse, release_pulse, toggle};
    vectors++;
    if (obs !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_mid_arm async: outputs=%b expected=0000", obs);
    end
    tick();
    obs = {pressed, press_pulse, release_pulse, toggle};
    vectors++;
    if (obs !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_mid_arm held: outputs=%b expected=0000", obs);
    end
    @(negedge CLK);
    reset = 1'b0;
    press_window("reset_mid_arm_repress");
  endtask

  task automatic test_repeat_presses();
    int unsigned pulses = 0;
    for (int r = 0; r < 3; r++) begin
      KEYb = 1'b0;
      for (int i = 1; i <= 8; i++) begin
        tick();
        if (press_pulse === 1'b1) pulses++;
        if (i == 6 && TOG_EN) exp_toggle = ~exp_toggle;
        vectors++;
        if (toggle !== exp_toggle) begin
          miscompares++;
          $display("FAIL repeat_toggle press %0d edge %0d: toggle=%b expected=%b",
                   r, i, toggle, exp_toggle);
        end
      end
      KEYb = 1'b1;
      for (int i = 1; i <= 8; i++) begin
        tick();
        if (press_pulse === 1'b1) pulses++;
      end
    end
    vectors++;
    if (pulses != 3) begin
      miscompares++;
      $display("FAIL repeat_press_count: pulses=%0d expected=3", pulses);
    end
    vectors++;
    if (toggle !== (TOG_EN ? 1'b0 : 1'b0) ^ exp_toggle) begin
      miscompares++;
      $display("FAIL repeat_final_toggle: toggle=%b expected=%b", toggle, exp_toggle);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release("release");
    test_short_glitch();
    test_bounce();
    test_release("release_after_bounce");
    test_reset_mid_arm();
    test_release("release_after_reset");
    test_repeat_presses();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
